// File: rtl/display_scan_ctrl_pkg.sv
// Shared slot encodings, BCD limits and digit helpers for the display scan controller.
// The digit struct follows the HH:MM nibble order of the packed input bus.
package display_pkg;

    typedef enum logic [1:0] {
        SLOT_HT = 2'b00,
        SLOT_HU = 2'b01,
        SLOT_MT = 2'b10,
        SLOT_MU = 2'b11
    } slot_t;

    localparam slot_t      COLON_SLOT        = SLOT_HU;
    localparam logic [3:0] BCD_MAX           = 4'd9;
    localparam int         SCAN_DIV_DEFAULT  = 100000;
    localparam int         BLINK_DIV_DEFAULT = 50000000;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t ht;
        bcd_t hu;
        bcd_t mt;
        bcd_t mu;
    } digits_t;

    // The downstream decoder has no default case, so out-of-range nibbles become 0.
    function automatic bcd_t clamp_bcd(input logic [3:0] v);
        return (v > BCD_MAX) ? 4'd0 : v;
    endfunction

    function automatic digits_t clamp_digits(input logic [15:0] d);
        digits_t r;
        r.ht = clamp_bcd(d[15:12]);
        r.hu = clamp_bcd(d[11:8]);
        r.mt = clamp_bcd(d[7:4]);
        r.mu = clamp_bcd(d[3:0]);
        return r;
    endfunction

    function automatic bcd_t select_digit(input digits_t d, input slot_t s);
        bcd_t r;
        case (s)
            SLOT_HT: r = d.ht;
            SLOT_HU: r = d.hu;
            SLOT_MT: r = d.mt;
            default: r = d.mu;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Digit/colon inputs from the clock datapath and the scan outputs to the seven-segment decoder.
// The master side is the scan controller; the slave side is its surrounding datapath.
interface display_scan_ctrl_if;

    logic [15:0] digits;
    logic        colon_en;
    logic        colon_blink;
    logic [1:0]  led;
    logic [3:0]  x;
    logic        dot;
    logic        frame_tick;

    modport master (
        input  digits,
        input  colon_en,
        input  colon_blink,
        output led,
        output x,
        output dot,
        output frame_tick
    );

    modport slave (
        output digits,
        output colon_en,
        output colon_blink,
        input  led,
        input  x,
        input  dot,
        input  frame_tick
    );

endinterface

// File: rtl/display_scan_ctrl_tick_gen.sv
// Modulo-N free-running counter; tc is high for the single cycle the count sits at N-1.
// Used as both the digit-slot prescaler and the colon blink timer.
module tick_gen #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tc
);

    localparam int         W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit time-multiplexed scan controller with per-frame digit snapshot and colon blink.
// led, x and dot are all registered from the same next-state values, so they move together.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int SCAN_DIV  = SCAN_DIV_DEFAULT,
    parameter int BLINK_DIV = BLINK_DIV_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    display_scan_ctrl_if.master bus
);

    logic    slot_tc;
    logic    blink_tc;
    slot_t   led_q;
    slot_t   led_next;
    digits_t shadow;
    digits_t shadow_next;
    logic    phase;
    logic    phase_next;
    logic    snap;
    bcd_t    x_q;
    logic    dot_q;
    logic    frame_tick_q;

    tick_gen #(.N(SCAN_DIV)) u_slot_tick (
        .clk (clk),
        .rst (rst),
        .tc  (slot_tc)
    );

    tick_gen #(.N(BLINK_DIV)) u_blink_tick (
        .clk (clk),
        .rst (rst),
        .tc  (blink_tc)
    );

    // Snapshot happens on the last slot's tc, so the new frame starts with fresh digits.
    always_comb begin
        led_next    = led_q;
        shadow_next = shadow;
        snap        = slot_tc && (led_q == SLOT_MU);
        phase_next  = phase ^ blink_tc;
        if (slot_tc) begin
            led_next = slot_t'(led_q + 2'd1);
        end
        if (snap) begin
            shadow_next = clamp_digits(bus.digits);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q        <= SLOT_HT;
            shadow       <= '0;
            phase        <= 1'b0;
            x_q          <= '0;
            dot_q        <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            led_q        <= led_next;
            shadow       <= shadow_next;
            phase        <= phase_next;
            x_q          <= select_digit(shadow_next, led_next);
            dot_q        <= (led_next == COLON_SLOT) && bus.colon_en
                            && (!bus.colon_blink || phase_next);
            frame_tick_q <= snap;
        end
    end

    assign bus.led        = led_q;
    assign bus.x          = x_q;
    assign bus.dot        = dot_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomised bench for display_scan_ctrl against a cycle-count reference model.
// Expected outputs are derived from the number of clocks since reset with plain division.
module tb_display_scan_ctrl;

    localparam int SCAN  = 4;
    localparam int BLINK = 10;
    localparam int FRAME = 4 * SCAN;

    logic clk = 1'b0;
    logic rst = 1'b1;

    display_scan_ctrl_if bus ();

    display_scan_ctrl #(
        .SCAN_DIV  (SCAN),
        .BLINK_DIV (BLINK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    int         c           = 0;
    logic [3:0] sh [4];
    logic       en_s        = 1'b0;
    logic       bl_s        = 1'b0;
    logic [7:0] obs;
    logic [7:0] exp_v;

    // Model: one edge of the clock, using the inputs the DUT sees at that edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            c = 0;
            for (int i = 0; i < 4; i++) sh[i] = 4'd0;
            en_s = 1'b0;
            bl_s = 1'b0;
        end else begin
            c++;
            if (c % FRAME == 0) begin
                for (int i = 0; i < 4; i++) begin
                    logic [3:0] n;
                    n = bus.digits[15 - 4*i -: 4];
                    sh[i] = (n > 4'd9) ? 4'd0 : n;
                end
            end
            en_s = bus.colon_en;
            bl_s = bus.colon_blink;
        end
        #1;
    endtask

    function automatic logic [7:0] model_out();
        int   s;
        int   ph;
        logic d;
        logic ft;
        s  = (c / SCAN) % 4;
        ph = (c / BLINK) % 2;
        d  = (s == 1) && en_s && (!bl_s || ph == 1);
        ft = (c > 0) && (c % FRAME == 0);
        return {2'(s), sh[s], d, ft};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.digits = 16'h0000;
        bus.colon_en = 1'b0;
        bus.colon_blink = 1'b0;
        repeat (3) begin
            tick();
            obs = {bus.led, bus.x, bus.dot, bus.frame_tick};
            vectors++;
            if (obs !== 8'h00) begin
                miscompares++;
                $display("[TB] FAIL reset_hold: got led=%0d x=%0d dot=%b ft=%b, expected all zero",
                         obs[7:6], obs[5:2], obs[1], obs[0]);
            end
        end
        rst = 1'b0;
        bus.digits = 16'h1234;
        repeat (2 * FRAME + 4) begin
            tick();
            obs = {bus.led, bus.x, bus.dot, bus.frame_tick};
            exp_v = model_out();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL first_frame c=%0d: got led=%0d x=%0d dot=%b ft=%b, expected led=%0d x=%0d dot=%b ft=%b",
                         c, obs[7:6], obs[5:2], obs[1], obs[0], exp_v[7:6], exp_v[5:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    task automatic test_tear_free();
        for (int k = 0; k < FRAME && ((c / SCAN) % 4) != 1; k++) tick();
        bus.digits = 16'h5678;
        repeat (FRAME + 8) begin
            tick();
            obs = {bus.led, bus.x, bus.dot, bus.frame_tick};
            exp_v = model_out();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL tear_free c=%0d: got led=%0d x=%0d ft=%b, expected led=%0d x=%0d ft=%b",
                         c, obs[7:6], obs[5:2], obs[0], exp_v[7:6], exp_v[5:2], exp_v[0]);
            end
        end
    endtask

    task automatic test_clamp();
        bus.digits = 16'hA9F0;
        repeat (2 * FRAME) begin
            tick();
            obs = {bus.led, bus.x, bus.dot, bus.frame_tick};
            exp_v = model_out();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL clamp c=%0d: got led=%0d x=%0d, expected led=%0d x=%0d",
                         c, obs[7:6], obs[5:2], exp_v[7:6], exp_v[5:2]);
            end
        end
    endtask

    task automatic test_colon_modes();
        logic [1:0] modes [3];
        modes[0] = 2'b10;
        modes[1] = 2'b00;
        modes[2] = 2'b11;
        for (int m = 0; m < 3; m++) begin
            bus.colon_en    = modes[m][1];
            bus.colon_blink = modes[m][0];
            repeat (3 * FRAME) begin
                bus.digits = 16'($urandom);
                tick();
                obs = {bus.led, bus.x, bus.dot, bus.frame_tick};
                exp_v = model_out();
                vectors++;
                if (obs !== exp_v) begin
                    miscompares++;
                    $display("[TB] FAIL colon_mode%0d c=%0d: got led=%0d x=%0d dot=%b, expected led=%0d x=%0d dot=%b",
                             m, c, obs[7:6], obs[5:2], obs[1], exp_v[7:6], exp_v[5:2], exp_v[1]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        bus.digits = 16'h5678;
        bus.colon_en = 1'b1;
        bus.colon_blink = 1'b0;
        repeat (FRAME + 2) tick();
        for (int k = 0; k < FRAME && ((c / SCAN) % 4) != 2; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        obs = {bus.led, bus.x, bus.dot, bus.frame_tick};
        vectors++;
        if (obs !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: got led=%0d x=%0d dot=%b ft=%b, expected all zero",
                     obs[7:6], obs[5:2], obs[1], obs[0]);
        end
        repeat (FRAME + 6) begin
            tick();
            obs = {bus.led, bus.x, bus.dot, bus.frame_tick};
            exp_v = model_out();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL after_reset c=%0d: got led=%0d x=%0d dot=%b ft=%b, expected led=%0d x=%0d dot=%b ft=%b",
                         c, obs[7:6], obs[5:2], obs[1], obs[0], exp_v[7:6], exp_v[5:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    // Slot tc and blink tc coincide at 20 clocks after reset, entering the colon slot.
    task automatic test_coincident();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.colon_en = 1'b1;
        bus.colon_blink = 1'b1;
        repeat (24) begin
            tick();
            obs = {bus.led, bus.x, bus.dot, bus.frame_tick};
            exp_v = model_out();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL coincident c=%0d: got led=%0d dot=%b, expected led=%0d dot=%b",
                         c, obs[7:6], obs[1], exp_v[7:6], exp_v[1]);
            end
        end
    endtask

    task automatic test_random();
        repeat (300) begin
            bus.digits      = 16'($urandom);
            bus.colon_en    = 1'($urandom_range(0, 3) != 0);
            bus.colon_blink = 1'($urandom);
            tick();
            obs = {bus.led, bus.x, bus.dot, bus.frame_tick};
            exp_v = model_out();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL random c=%0d: got led=%0d x=%0d dot=%b ft=%b, expected led=%0d x=%0d dot=%b ft=%b",
                         c, obs[7:6], obs[5:2], obs[1], obs[0], exp_v[7:6], exp_v[5:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_tear_free();
        test_clamp();
        test_colon_modes();
        test_mid_reset();
        test_coincident();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
